// File: rtl/rob_multi_commit.sv
// rob_multi_commit: in-order reorder buffer with multi-port completion and
// multi-slot commit.
//
// Entries are allocated in program order at the tail. The CDB ports and the
// store unit mark entries complete. Up to COMMIT_W ready entries retire from
// the head each cycle. A partial flush trims the tail back to just after a
// mispredicted branch. flush_all empties the buffer.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   alloc_*                allocation request (type, dest, ready-at-alloc)
//   alloc_ok / alloc_tag   buffer not full / tag the allocation receives
//   cdb_valid/tag/data     CDB_PORTS packed completion ports
//   st_valid/tag/addr/data store completion; st_stall blocks store commit
//   flush_all              empty the buffer
//   flush_valid/flush_tag  squash every entry younger than flush_tag
//   commit_*               per-slot commit outputs, slot k = head+k
//   count                  occupancy, 0..DEPTH
module rob_multi_commit #(
  parameter int DEPTH     = 16,
  parameter int DATA_W    = 32,
  parameter int REG_W     = 6,
  parameter int CDB_PORTS = 2,
  parameter int COMMIT_W  = 2,
  parameter int TAG_W     = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          alloc_valid,
  input  logic [1:0]                    alloc_type,
  input  logic [REG_W-1:0]              alloc_reg_dest,
  input  logic                          alloc_ready_init,
  output logic                          alloc_ok,
  output logic [TAG_W-1:0]              alloc_tag,
  input  logic [CDB_PORTS-1:0]          cdb_valid,
  input  logic [CDB_PORTS*TAG_W-1:0]    cdb_tag,
  input  logic [CDB_PORTS*DATA_W-1:0]   cdb_data,
  input  logic                          st_valid,
  input  logic [TAG_W-1:0]              st_tag,
  input  logic [DATA_W-1:0]             st_addr,
  input  logic [DATA_W-1:0]             st_data,
  input  logic                          st_stall,
  input  logic                          flush_all,
  input  logic                          flush_valid,
  input  logic [TAG_W-1:0]              flush_tag,
  output logic [COMMIT_W-1:0]           commit_valid,
  output logic [COMMIT_W*2-1:0]         commit_type,
  output logic [COMMIT_W*REG_W-1:0]     commit_reg_dest,
  output logic [COMMIT_W*DATA_W-1:0]    commit_value,
  output logic [COMMIT_W*DATA_W-1:0]    commit_addr,
  output logic [TAG_W:0]                count
);
  localparam int         PTR_W   = TAG_W + 1;
  localparam logic [1:0] TYPE_ST = 2'd2;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [PTR_W-1:0]  head_reg, tail_reg, head_next, tail_next;
  logic [PTR_W-1:0]  count_w, n_commit, flush_tail;
  logic [TAG_W-1:0]  head_idx, tail_idx, flush_age;
  logic              full, alloc_fire, commit_chain;

  logic [1:0]        type_reg  [DEPTH];
  logic [REG_W-1:0]  dest_reg  [DEPTH];
  logic [DATA_W-1:0] value_reg [DEPTH];
  logic [DATA_W-1:0] addr_reg  [DEPTH];
  logic [DEPTH-1:0]  ready_reg;

  logic [TAG_W-1:0]  slot_idx  [COMMIT_W];
  logic [TAG_W-1:0]  entry_age [DEPTH];
  logic [DEPTH-1:0]  live, squash, retire;

  assign head_idx   = head_reg[TAG_W-1:0];
  assign tail_idx   = tail_reg[TAG_W-1:0];
  assign count_w    = tail_reg - head_reg;
  assign full       = (head_idx == tail_idx) && (head_reg[TAG_W] != tail_reg[TAG_W]);
  assign alloc_ok   = !full;
  assign alloc_tag  = tail_idx;
  assign count      = count_w;
  assign alloc_fire = alloc_valid && !full && !flush_all && !flush_valid;

  // The age of the branch is measured from the pre-commit head. Adding it to
  // the full-width head yields a tail whose wrap bit is consistent.
  assign flush_age  = flush_tag - head_idx;
  assign flush_tail = head_reg + {1'b0, flush_age} + PTR_W'(1);

  assign head_next  = head_reg + n_commit;
  assign tail_next  = flush_valid ? flush_tail
                                  : tail_reg + {{TAG_W{1'b0}}, alloc_fire};

  for (genvar gi = 0; gi < COMMIT_W; gi++) begin : g_slot
    assign slot_idx[gi]                            = head_idx + TAG_W'(gi);
    assign commit_type[gi*2 +: 2]                  = type_reg[slot_idx[gi]];
    assign commit_reg_dest[gi*REG_W +: REG_W]      = dest_reg[slot_idx[gi]];
    assign commit_value[gi*DATA_W +: DATA_W]       = value_reg[slot_idx[gi]];
    assign commit_addr[gi*DATA_W +: DATA_W]        = addr_reg[slot_idx[gi]];
  end

  // An entry accepts a completion only while it is occupied and survives any
  // partial flush in the same cycle. Entries younger than the branch are
  // squashed.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    assign entry_age[gi] = TAG_W'(gi) - head_idx;
    assign squash[gi]    = flush_valid && (entry_age[gi] > flush_age);
    assign live[gi]      = ({1'b0, entry_age[gi]} < count_w) && !squash[gi];
  end

  // Commit slots form an unbroken chain from the head. A store ends the chain:
  // the store commits in its own slot, and no slot after it is valid.
  always_comb begin
    commit_valid = '0;
    n_commit     = '0;
    commit_chain = !flush_all;
    for (int k = 0; k < COMMIT_W; k++) begin
      if (commit_chain && (PTR_W'(k) < count_w) && ready_reg[slot_idx[k]] &&
          ((type_reg[slot_idx[k]] != TYPE_ST) || !st_stall)) begin
        commit_valid[k] = 1'b1;
        n_commit        = n_commit + PTR_W'(1);
        if (type_reg[slot_idx[k]] == TYPE_ST) begin
          commit_chain = 1'b0;
        end
      end else begin
        commit_chain = 1'b0;
      end
    end
  end

  always_comb begin
    retire = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int k = 0; k < COMMIT_W; k++) begin
        if (commit_valid[k] && (slot_idx[k] == TAG_W'(i))) begin
          retire[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      ready_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        type_reg[i]  <= '0;
        dest_reg[i]  <= '0;
        value_reg[i] <= '0;
        addr_reg[i]  <= '0;
      end
    end else if (flush_all) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      ready_reg <= '0;
    end else begin
      head_reg <= head_next;
      tail_reg <= tail_next;
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_fire && (tail_idx == TAG_W'(i))) begin
          type_reg[i]  <= alloc_type;
          dest_reg[i]  <= alloc_reg_dest;
          ready_reg[i] <= alloc_ready_init;
          value_reg[i] <= '0;
          addr_reg[i]  <= '0;
        end
        // Ascending port order: the highest-numbered port wins.
        for (int p = 0; p < CDB_PORTS; p++) begin
          if (cdb_valid[p] && (cdb_tag[p*TAG_W +: TAG_W] == TAG_W'(i)) && live[i]) begin
            value_reg[i] <= cdb_data[p*DATA_W +: DATA_W];
            ready_reg[i] <= 1'b1;
          end
        end
        if (st_valid && (st_tag == TAG_W'(i)) && live[i]) begin
          value_reg[i] <= st_data;
          addr_reg[i]  <= st_addr;
          ready_reg[i] <= 1'b1;
        end
        if (retire[i] || squash[i]) begin
          ready_reg[i] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_rob_multi_commit.sv
// tb_rob_multi_commit: directed scenarios plus randomized traffic. The
// reference model is an in-order queue of entries, where the head sits at
// position 0.
module tb_rob_multi_commit;
  localparam int DEPTH = 16, DATA_W = 32, REG_W = 6, CDB_PORTS = 2, COMMIT_W = 2;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                        rst_n, alloc_valid, alloc_ready_init, alloc_ok;
  logic [1:0]                  alloc_type;
  logic [REG_W-1:0]            alloc_reg_dest;
  logic [TAG_W-1:0]            alloc_tag, st_tag, flush_tag;
  logic [CDB_PORTS-1:0]        cdb_valid;
  logic [CDB_PORTS*TAG_W-1:0]  cdb_tag;
  logic [CDB_PORTS*DATA_W-1:0] cdb_data;
  logic                        st_valid, st_stall, flush_all, flush_valid;
  logic [DATA_W-1:0]           st_addr, st_data;
  logic [COMMIT_W-1:0]         commit_valid;
  logic [COMMIT_W*2-1:0]       commit_type;
  logic [COMMIT_W*REG_W-1:0]   commit_reg_dest;
  logic [COMMIT_W*DATA_W-1:0]  commit_value, commit_addr;
  logic [TAG_W:0]              count;

  rob_multi_commit #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W),
                     .CDB_PORTS(CDB_PORTS), .COMMIT_W(COMMIT_W)) dut (
    .clk(clk), .rst_n(rst_n), .alloc_valid(alloc_valid), .alloc_type(alloc_type),
    .alloc_reg_dest(alloc_reg_dest), .alloc_ready_init(alloc_ready_init),
    .alloc_ok(alloc_ok), .alloc_tag(alloc_tag), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_data(cdb_data), .st_valid(st_valid), .st_tag(st_tag),
    .st_addr(st_addr), .st_data(st_data), .st_stall(st_stall),
    .flush_all(flush_all), .flush_valid(flush_valid), .flush_tag(flush_tag),
    .commit_valid(commit_valid), .commit_type(commit_type),
    .commit_reg_dest(commit_reg_dest), .commit_value(commit_value),
    .commit_addr(commit_addr), .count(count)
  );

  typedef struct {
    logic [1:0]        typ;
    logic [REG_W-1:0]  dest;
    logic              ready;
    logic [DATA_W-1:0] value;
    logic [DATA_W-1:0] addr;
  } ent_t;

  ent_t q[$];
  int   head = 0;
  int   tests = 0, fails = 0;
  logic [COMMIT_W-1:0] obs_cv;
  logic [1:0]          obs_type0;

  task automatic chk(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int pos_of(int tag);
    return (tag - head + DEPTH) % DEPTH;
  endfunction

  // Compute how many entries retire this cycle under the current inputs.
  function automatic int exp_commits();
    int n = 0;
    if (flush_all) return 0;
    for (int k = 0; k < COMMIT_W && k < q.size(); k++) begin
      if (!q[k].ready) break;
      if (q[k].typ == 2'd2) begin
        if (!st_stall) n++;
        break;
      end
      n++;
    end
    return n;
  endfunction

  task automatic model_update(int n);
    int   size0, fpos, pos;
    ent_t e;
    if (flush_all) begin
      q.delete();
      head = 0;
      return;
    end
    size0 = q.size();
    fpos  = flush_valid ? pos_of(int'(flush_tag)) : DEPTH;
    for (int p = 0; p < CDB_PORTS; p++) begin
      if (cdb_valid[p]) begin
        pos = pos_of(int'(cdb_tag[p*TAG_W +: TAG_W]));
        if (pos < size0 && pos <= fpos) begin
          e = q[pos]; e.value = cdb_data[p*DATA_W +: DATA_W]; e.ready = 1'b1; q[pos] = e;
        end
      end
    end
    if (st_valid) begin
      pos = pos_of(int'(st_tag));
      if (pos < size0 && pos <= fpos) begin
        e = q[pos]; e.value = st_data; e.addr = st_addr; e.ready = 1'b1; q[pos] = e;
      end
    end
    if (flush_valid) while (q.size() > fpos + 1) void'(q.pop_back());
    for (int k = 0; k < n; k++) begin
      void'(q.pop_front());
      head = (head + 1) % DEPTH;
    end
    if (alloc_valid && size0 < DEPTH && !flush_valid) begin
      e.typ = alloc_type; e.dest = alloc_reg_dest; e.ready = alloc_ready_init;
      e.value = '0; e.addr = '0;
      q.push_back(e);
    end
  endtask

  // One clock cycle: check every output at the falling edge, then advance the
  // model at the rising edge.
  task automatic step();
    int n;
    logic [COMMIT_W-1:0] ecv;
    @(negedge clk);
    n   = exp_commits();
    ecv = COMMIT_W'((1 << n) - 1);
    chk("count", longint'(count), longint'(q.size()));
    chk("alloc_ok", longint'(alloc_ok), longint'(q.size() < DEPTH));
    chk("alloc_tag", longint'(alloc_tag), longint'((head + q.size()) % DEPTH));
    chk("commit_valid", longint'(commit_valid), longint'(ecv));
    obs_cv    = commit_valid;
    obs_type0 = commit_type[1:0];
    for (int k = 0; k < n; k++) begin
      chk("commit_type", longint'(commit_type[k*2 +: 2]), longint'(q[k].typ));
      chk("commit_dest", longint'(commit_reg_dest[k*REG_W +: REG_W]), longint'(q[k].dest));
      chk("commit_value", longint'(commit_value[k*DATA_W +: DATA_W]), longint'(q[k].value));
      chk("commit_addr", longint'(commit_addr[k*DATA_W +: DATA_W]), longint'(q[k].addr));
      $display("[TB] commit tag=%0d type=%0d dest=%0d value=%h addr=%h",
               (head + k) % DEPTH, q[k].typ, q[k].dest, q[k].value, q[k].addr);
    end
    @(posedge clk);
    model_update(n);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 0; alloc_type = 0; alloc_reg_dest = 0; alloc_ready_init = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
    st_valid = 0; st_tag = 0; st_addr = 0; st_data = 0; st_stall = 0;
    flush_all = 0; flush_valid = 0; flush_tag = 0;
  endtask

  task automatic alloc_one(logic [1:0] t, int dest, logic rdy);
    idle();
    alloc_valid = 1; alloc_type = t; alloc_reg_dest = REG_W'(dest); alloc_ready_init = rdy;
    step();
  endtask

  task automatic do_flush_all();
    idle(); flush_all = 1; step(); idle();
  endtask

  initial begin
    int n, fp, pos;
    logic [TAG_W-1:0] t;
    logic clash;

    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    q.delete(); head = 0;
    #1 rst_n = 1;
    @(negedge clk);
    chk("reset_count", longint'(count), 0);
    chk("reset_alloc_ok", longint'(alloc_ok), 1);
    chk("reset_alloc_tag", longint'(alloc_tag), 0);
    chk("reset_commit_valid", longint'(commit_valid), 0);
    @(posedge clk); #1;

    // Scenario 1: fill the buffer; the 17th request is dropped.
    for (int i = 0; i < DEPTH; i++) begin
      idle(); alloc_valid = 1; alloc_type = 2'd3; alloc_reg_dest = REG_W'(i);
      chk("fill_alloc_tag", longint'(alloc_tag), i);
      step();
    end
    chk("full_count", longint'(count), 16);
    chk("full_alloc_ok", longint'(alloc_ok), 0);
    alloc_one(2'd3, 63, 1'b0);
    chk("full_drop_count", longint'(count), 16);
    chk("full_drop_tag", longint'(alloc_tag), 0);
    do_flush_all();
    chk("flush_all_count", longint'(count), 0);

    // Scenario 2: completions arrive out of order; two entries commit together.
    for (int i = 0; i < 3; i++) alloc_one(2'd3, 10 + i, 1'b0);
    idle(); cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd1}; cdb_data = {32'h0, 32'h111}; step();
    idle(); cdb_valid = 2'b10; cdb_tag = {4'd0, 4'd0}; cdb_data = {32'h200, 32'h0}; step();
    idle(); step();
    chk("dual_commit", longint'(obs_cv), 2'b11);
    idle(); cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd2}; cdb_data = {32'h0, 32'h333}; step();
    chk("tag2_not_yet", longint'(obs_cv), 0);
    idle(); step();
    chk("tag2_commit", longint'(obs_cv), 2'b01);

    // Scenario 3: a store at the head is held back by st_stall.
    do_flush_all();
    idle(); alloc_valid = 1; alloc_type = 2'd2; alloc_ready_init = 1; st_stall = 1; step();
    idle(); alloc_valid = 1; alloc_type = 2'd3; alloc_reg_dest = 6'd5;
    alloc_ready_init = 1; st_stall = 1; step();
    for (int i = 0; i < 3; i++) begin
      idle(); st_stall = 1; step();
      chk("st_stall_hold", longint'(obs_cv), 0);
    end
    idle(); step();
    chk("st_alone", longint'(obs_cv), 2'b01);
    chk("st_alone_type", longint'(obs_type0), 2);
    idle(); step();
    chk("reg_after_st", longint'(obs_cv), 2'b01);
    chk("reg_after_st_type", longint'(obs_type0), 3);

    // Scenario 4: a partial flush happens while the head commits.
    do_flush_all();
    for (int i = 0; i < 6; i++) alloc_one(2'd3, 20 + i, 1'b0);
    idle(); cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd0}; cdb_data = {32'h0, 32'hAAAA}; step();
    idle(); flush_valid = 1; flush_tag = 4'd2;
    cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd4}; cdb_data = {32'h0, 32'hBAD}; step();
    chk("pflush_commit", longint'(obs_cv), 2'b01);
    idle();
    chk("pflush_count", longint'(count), 2);
    chk("pflush_tail", longint'(alloc_tag), 3);
    alloc_one(2'd3, 30, 1'b0);
    alloc_one(2'd3, 31, 1'b0);
    idle(); cdb_valid = 2'b11; cdb_tag = {4'd2, 4'd1}; cdb_data = {32'h22, 32'h11}; step();
    idle(); step();
    chk("pflush_survivors", longint'(obs_cv), 2'b11);
    idle(); step();
    chk("pflush_left", longint'(count), 2);

    // Scenario 5: steady streaming across many pointer wraps.
    do_flush_all();
    for (int i = 0; i < DEPTH - 1; i++) alloc_one(2'd3, i, 1'b0);
    idle(); cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd0}; cdb_data = {32'h0, 32'h5}; step();
    for (int i = 0; i < 40; i++) begin
      idle(); alloc_valid = 1; alloc_type = 2'd3; alloc_reg_dest = REG_W'($urandom);
      cdb_valid = 2'b01; cdb_tag[TAG_W-1:0] = TAG_W'((head + 1) % DEPTH);
      cdb_data[DATA_W-1:0] = $urandom;
      step();
      chk("stream_count", longint'(count), 15);
    end

    // Scenario 6: flush_all with a ready entry at the head.
    do_flush_all();
    chk("fa_no_commit", longint'(obs_cv), 0);
    chk("fa_count", longint'(count), 0);
    chk("fa_alloc_tag", longint'(alloc_tag), 0);

    // Randomized traffic.
    for (int cyc = 0; cyc < 600; cyc++) begin
      idle();
      st_stall  = ($urandom % 4) == 0;
      flush_all = ($urandom % 64) == 0;
      n = exp_commits();
      if (!flush_all && q.size() > n && ($urandom % 12) == 0) begin
        fp = $urandom_range(q.size() - 1, n);
        flush_valid = 1;
        flush_tag = TAG_W'((head + fp) % DEPTH);
      end
      alloc_valid      = ($urandom % 3) != 0;
      alloc_type       = 2'($urandom);
      alloc_reg_dest   = REG_W'($urandom);
      alloc_ready_init = ($urandom % 4) == 0;
      for (int p = 0; p < CDB_PORTS; p++) begin
        pos = $urandom % DEPTH;
        if (($urandom % 2) == 1 && pos >= n) begin
          cdb_valid[p] = 1'b1;
          cdb_tag[p*TAG_W +: TAG_W] = TAG_W'((head + pos) % DEPTH);
          cdb_data[p*DATA_W +: DATA_W] = $urandom;
        end
      end
      pos = $urandom % DEPTH;
      if (($urandom % 2) == 1 && pos >= n) begin
        t = TAG_W'((head + pos) % DEPTH);
        clash = 1'b0;
        for (int p = 0; p < CDB_PORTS; p++)
          if (cdb_valid[p] && cdb_tag[p*TAG_W +: TAG_W] == t) clash = 1'b1;
        if (!clash) begin
          st_valid = 1; st_tag = t; st_addr = $urandom; st_data = $urandom;
        end
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
